reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of the wd/rd1/rd2 ports.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; register count = 2**ADDR_WIDTH (32).
REQ-003 Port clk  input  1  sole clock; all writes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port wr_en  input  1  write enable, sampled at rising clk.
REQ-006 Port wd  input  DATA_WIDTH  write data.
REQ-007 Port wr  input  ADDR_WIDTH  write register index.
REQ-008 Port rr1  input  ADDR_WIDTH  read port 1 register index.
REQ-009 Port rr2  input  ADDR_WIDTH  read port 2 register index.
REQ-010 Port rd1  output  DATA_WIDTH  read port 1 data.
REQ-011 Port rd2  output  DATA_WIDTH  read port 2 data.

Function
REQ-012 The block SHALL hold 2**ADDR_WIDTH registers x0..x31, each DATA_WIDTH bits wide.
REQ-013 Register x0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-014 On a rising clk edge with wr_en=1, reset=0 and wr!=0, register[wr] SHALL take wd.
REQ-015 With wr_en=0, no register SHALL change.
REQ-016 Reads SHALL be combinational, with zero-cycle latency: rd1 = register[rr1] and rd2 = register[rr2], updating as soon as the index or the addressed contents change.
REQ-017 A write SHALL become visible on the read ports immediately after the rising edge that performs it.
REQ-018 Both read ports SHALL be independent; rr1==rr2 SHALL return identical data on both ports.
REQ-019 Without the bypass feature (REQ-024), a read of index wr during the write cycle SHALL return the old value until the edge.
REQ-020 Unknown (X) values on wr_en SHALL NOT be required to be handled; the design is exercised with defined inputs only.

Reset
REQ-021 While reset=1, all registers SHALL be cleared to 0 asynchronously, without waiting for clk, and rd1/rd2 SHALL read 0 for every index.
REQ-022 While reset=1, writes SHALL be ignored, and reset SHALL take priority over a simultaneous write.
REQ-023 After reset deasserts, the first write SHALL occur on the first rising edge with wr_en=1.

Configuration
REQ-024 Macro REG_FILE_WRITE_BYPASS_EN:
- If defined: when wr_en=1, wr!=0, reset=0 and rrN==wr, rdN SHALL combinationally return wd (write-first forwarding).
- If not defined: no forwarding; REQ-019 applies.
- x0 SHALL read 0 in both builds.

Verification
REQ-025 Assert reset for 2 cycles, then read all 32 indices -> every read returns 0x00000000.
REQ-026 wr_en=1, wr=0, wd=0xFFFFFFFF; then rr1=0 -> rd1=0x00000000.
REQ-027 Write wr=1/wd=0x1, then wr=2/wd=0x2, then wr=7/wd=0x12; read rr1=2, rr2=7 -> rd1=0x00000002, rd2=0x00000012; rr1=rr2=1 -> both 0x00000001.
REQ-028 wr_en=0, wr=7, wd=0xDEADBEEF for 2 edges; rr2=7 -> rd2 stays 0x00000012.
REQ-029 Write wr=3, wd=0xA5A5A5A5 with rr1=3 in the same cycle -> before the edge, rd1 = old value (0) without the macro and 0xA5A5A5A5 with REG_FILE_WRITE_BYPASS_EN; after the edge, both builds read 0xA5A5A5A5.
REQ-030 Assert reset mid-cycle, between edges, after registers are written -> rd1/rd2 drop to 0 immediately; a write edge during reset leaves registers at 0.

Source files
------------

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//
// Purpose:
//   General-purpose register file with 2**ADDR_WIDTH registers (x0..xN-1),
//   one synchronous write port and two independent combinational read ports.
//   Register x0 is hard-wired to zero: writes to index 0 are dropped and reads
//   of index 0 always return 0.
//
// Ports:
//   clk    in   1           sole clock, writes happen on the rising edge
//   reset  in   1           asynchronous, active-high; clears every register
//   wr_en  in   1           write enable, sampled on the rising edge
//   wd     in   DATA_WIDTH  write data
//   wr     in   ADDR_WIDTH  write register index
//   rr1    in   ADDR_WIDTH  read port 1 register index
//   rr2    in   ADDR_WIDTH  read port 2 register index
//   rd1    out  DATA_WIDTH  read port 1 data (zero-cycle latency)
//   rd2    out  DATA_WIDTH  read port 2 data (zero-cycle latency)
//
// Configuration:
//   REG_FILE_WRITE_BYPASS_EN  when defined, a read of the index being written
//                             in the current cycle returns wd (write-first
//                             forwarding). When undefined, such a read returns
//                             the stored value until the write edge.
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [ADDR_WIDTH-1:0] wr,
    input  logic [ADDR_WIDTH-1:0] rr1,
    input  logic [ADDR_WIDTH-1:0] rr2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Storage. Entry 0 exists in the array for uniform indexing but is never
    // written, and the read muxes force it to zero regardless.
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // A write is only effective for a nonzero index; reset blocks it in the
    // flop process below, so it does not need to appear here.
    logic write_active;

    assign write_active = wr_en && (wr != '0);

    // Next-state: every register holds unless it is the target of an
    // effective write this cycle.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (write_active) begin
            regs_d[wr] = wd;
        end
    end

    // Reset clears every register immediately, without waiting for clk, and
    // wins over any write that coincides with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REG_FILE_WRITE_BYPASS_EN
    // Write-first forwarding: a read that targets the register being written
    // this cycle sees the incoming data before the edge. Forwarding is
    // suppressed during reset so the ports read zero while reset is held.
    logic bypass1;
    logic bypass2;

    assign bypass1 = write_active && !reset && (rr1 == wr);
    assign bypass2 = write_active && !reset && (rr2 == wr);

    always_comb begin
        rd1 = '0;
        if (rr1 == '0) begin
            rd1 = '0;
        end else if (bypass1) begin
            rd1 = wd;
        end else begin
            rd1 = regs_q[rr1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rr2 == '0) begin
            rd2 = '0;
        end else if (bypass2) begin
            rd2 = wd;
        end else begin
            rd2 = regs_q[rr2];
        end
    end
`else
    // Plain read ports: the stored value, with index 0 forced to zero. A read
    // of the register being written returns the old value until the edge.
    always_comb begin
        rd1 = '0;
        if (rr1 != '0) begin
            rd1 = regs_q[rr1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rr2 != '0) begin
            rd2 = regs_q[rr2];
        end
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven testbench for reg_file.
module tb_reg_file;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] wd;
   logic [AW-1:0] wr;
   logic [AW-1:0] rr1;
   logic [AW-1:0] rr2;
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;

   int checks;
   int failures;

   typedef struct {
      logic          wrEn;
      logic [AW-1:0] wrIdx;
      logic [DW-1:0] wrData;
      logic [AW-1:0] rIdx1;
      logic [AW-1:0] rIdx2;
      logic [DW-1:0] exp1;
      logic [DW-1:0] exp2;
   } vector_t;

   vector_t vectors[9];

   reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en),
      .wd    (wd),
      .wr    (wr),
      .rr1   (rr1),
      .rr2   (rr2),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a run that never finishes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drive one vector between edges, let it take effect on the next rising
   // edge, then compare both read ports shortly after that edge.
   task automatic applyStimulus(input int idx, input vector_t v);
      @(negedge clk);
      wr_en = v.wrEn;
      wr    = v.wrIdx;
      wd    = v.wrData;
      rr1   = v.rIdx1;
      rr2   = v.rIdx2;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_rd1", idx), rd1, v.exp1);
      checkOutput($sformatf("vec%0d_rd2", idx), rd2, v.exp2);
   endtask

   initial begin
      logic [DW-1:0] preEdgeExp;

      checks   = 0;
      failures = 0;

      //                wrEn wr     wd            rr1    rr2    exp1          exp2
      vectors[0] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
      vectors[1] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd0,  32'h00000001, 32'h00000000};
      vectors[2] = '{1'b1, 5'd2,  32'h00000002, 5'd2,  5'd1,  32'h00000002, 32'h00000001};
      vectors[3] = '{1'b1, 5'd7,  32'h00000012, 5'd2,  5'd7,  32'h00000002, 32'h00000012};
      vectors[4] = '{1'b0, 5'd7,  32'hDEADBEEF, 5'd1,  5'd7,  32'h00000001, 32'h00000012};
      vectors[5] = '{1'b0, 5'd7,  32'hDEADBEEF, 5'd1,  5'd7,  32'h00000001, 32'h00000012};
      vectors[6] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30, 32'h80000001, 32'h00000000};
      vectors[7] = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd1,  32'h00000001, 32'h00000001};
      vectors[8] = '{1'b1, 5'd2,  32'h5555AAAA, 5'd2,  5'd7,  32'h5555AAAA, 32'h00000012};

      // Reset for two cycles, with a write attempted while reset is held.
      reset = 1'b1;
      wr_en = 1'b1;
      wr    = 5'd5;
      wd    = 32'hCAFEF00D;
      rr1   = 5'd5;
      rr2   = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("write_during_reset", rd1, 32'h0);
      @(negedge clk);
      wr_en = 1'b0;
      reset = 1'b0;

      // Every index reads zero after reset, through both ports.
      for (int i = 0; i < 32; i++) begin
         rr1 = AW'(i);
         rr2 = AW'(31 - i);
         #1;
         checkOutput($sformatf("reset_rd1_x%0d", i), rd1, 32'h0);
         checkOutput($sformatf("reset_rd2_x%0d", 31 - i), rd2, 32'h0);
      end

      for (int i = 0; i < 9; i++) begin
         applyStimulus(i, vectors[i]);
      end

      // Combinational read: changing only the index updates rd without a clock.
      @(negedge clk);
      wr_en = 1'b0;
      rr1   = 5'd31;
      rr2   = 5'd1;
      #1;
      checkOutput("comb_rd1_x31", rd1, 32'h80000001);
      checkOutput("comb_rd2_x1", rd2, 32'h00000001);
      rr1 = 5'd7;
      #1;
      checkOutput("comb_rd1_x7", rd1, 32'h00000012);

      // Same-cycle read of the register being written.
`ifdef REG_FILE_WRITE_BYPASS_EN
      preEdgeExp = 32'hA5A5A5A5;
`else
      preEdgeExp = 32'h00000000;
`endif
      @(negedge clk);
      wr_en = 1'b1;
      wr    = 5'd3;
      wd    = 32'hA5A5A5A5;
      rr1   = 5'd3;
      rr2   = 5'd0;
      #1;
      checkOutput("same_cycle_pre_edge", rd1, preEdgeExp);
      checkOutput("same_cycle_x0", rd2, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("same_cycle_post_edge", rd1, 32'hA5A5A5A5);

      // Mid-cycle reset after registers hold data.
      @(negedge clk);
      wr_en = 1'b0;
      rr1   = 5'd3;
      rr2   = 5'd7;
      #1;
      checkOutput("pre_reset_rd1", rd1, 32'hA5A5A5A5);
      checkOutput("pre_reset_rd2", rd2, 32'h00000012);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_rd1", rd1, 32'h0);
      checkOutput("async_reset_rd2", rd2, 32'h0);
      @(negedge clk);
      wr_en = 1'b1;
      wr    = 5'd4;
      wd    = 32'h00001234;
      rr1   = 5'd4;
      rr2   = 5'd31;
      @(posedge clk);
      #1;
      checkOutput("reset_blocks_write", rd1, 32'h0);
      checkOutput("reset_cleared_x31", rd2, 32'h0);

      // Release reset between edges; the next edge with wr_en performs the write.
      @(negedge clk);
      reset = 1'b0;
      wr_en = 1'b0;
      #1;
      checkOutput("post_reset_x4", rd1, 32'h0);
      @(negedge clk);
      wr_en = 1'b1;
      wr    = 5'd4;
      wd    = 32'h00001234;
      @(posedge clk);
      #1;
      checkOutput("first_write_after_reset", rd1, 32'h00001234);
      checkOutput("x31_still_zero", rd2, 32'h0);

      @(negedge clk);
      wr_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
